// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
//   state_t     : sequencer states (IDLE, ISSUE, GUARD, WAIT, RESP)
//   WIDTH_DEF   : default operand width (product is twice this)
//   TIMEOUT_DEF : default number of WAIT cycles before giving up on mul_done
//   cnt_width() : timeout counter width, never narrower than 8 bits
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GUARD,
    WAIT,
    RESP
  } state_t;

  localparam int WIDTH_DEF   = 32;
  localparam int TIMEOUT_DEF = 255;

  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req       in  N_REQ  request vector
//   ptr       in  IW     highest-priority index for this pick
//   grant     out N_REQ  one-hot winner (all zero when no request)
//   grant_idx out IW     binary index of the winner (0 when no request)
// The winner is the first set bit of req scanning ptr, ptr+1, ... modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx
);

  // One extra bit so ptr+k never wraps before the modulo correction.
  localparam int IW1 = IW + 1;

  logic [IW:0] idx;
  logic        found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr} + IW1'(k);
      if (idx >= IW1'(N_REQ)) begin
        idx = idx - IW1'(N_REQ);
      end
      if (!found && req[idx[IW-1:0]]) begin
        found                 = 1'b1;
        grant[idx[IW-1:0]]    = 1'b1;
        grant_idx             = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one sequential multiplier among N_REQ requesters.
//   clk, rst      : clock (rising edge), asynchronous active-low reset
//   req_valid/ready, req_a/req_b : per-requester operand handshake; operands
//                   for requester i sit in slice [i*WIDTH +: WIDTH]
//   resp_valid/ready, resp_result, resp_err : one-hot response to the owner,
//                   shared result bus, timeout flag
//   mul_start, mul_a, mul_b, mul_result, mul_done : multiplier side
//   busy          : high whenever a request is in flight
// Sequence: IDLE -accept-> ISSUE (start pulse) -> GUARD (stale done ignored)
// -> WAIT (done or timeout) -> RESP (hold until owner takes it) -> IDLE.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       resp_valid,
  input  logic [N_REQ-1:0]       resp_ready,
  output logic [2*WIDTH-1:0]     resp_result,
  output logic                   resp_err,
  output logic                   mul_start,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  input  logic [2*WIDTH-1:0]     mul_result,
  input  logic                   mul_done,
  output logic                   busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = cnt_width(TIMEOUT);

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    owner;
  logic [N_REQ-1:0] owner_oh;
  logic [TW-1:0]    tcnt;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    grant_idx;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grant is offered only in IDLE; gating with rst keeps it low while reset
  // is held even if requests are already pending.
  assign req_ready = (rst && state == IDLE) ? grant : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      owner_oh    <= '0;
      tcnt        <= '0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      resp_valid  <= '0;
      resp_result <= '0;
      resp_err    <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            owner     <= grant_idx;
            owner_oh  <= grant;
            mul_a     <= req_a[grant_idx*WIDTH +: WIDTH];
            mul_b     <= req_b[grant_idx*WIDTH +: WIDTH];
            ptr       <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            mul_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= GUARD;
        end
        // mul_done may still be high from the previous product here.
        GUARD: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (mul_done) begin
            resp_result <= mul_result;
            resp_err    <= 1'b0;
            resp_valid  <= owner_oh;
            state       <= RESP;
          end else if (tcnt == TW'(TIMEOUT)) begin
            resp_result <= '0;
            resp_err    <= 1'b1;
            resp_valid  <= owner_oh;
            state       <= RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready[owner]) begin
            resp_valid <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic [N-1:0]     resp_valid;
  logic [N-1:0]     resp_ready = '0;
  logic [2*W-1:0]   resp_result;
  logic             resp_err;
  logic             mul_start;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic [2*W-1:0]   mul_result = '0;
  logic             mul_done = 1'b0;
  logic             busy;

  always #5 clk = ~clk;

  mult_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_err    (resp_err),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_result  (mul_result),
    .mul_done    (mul_done),
    .busy        (busy)
  );

  // Sequential multiplier: done rises mul_lat edges after start is sampled,
  // stays high until one edge after the next start. stub=1 never raises done.
  int          mul_lat = 3;
  bit          stub = 1'b0;
  int          mcnt = 0;
  bit          mpend = 1'b0;
  bit          mclr = 1'b0;
  logic [63:0] mprod = '0;

  always @(posedge clk) begin
    if (mul_start) begin
      mpend <= 1'b1;
      mcnt  <= mul_lat;
      mclr  <= 1'b1;
      mprod <= longint'($signed(mul_a)) * longint'($signed(mul_b));
    end else begin
      if (mclr) begin
        mul_done <= 1'b0;
        mclr     <= 1'b0;
      end
      if (mpend) begin
        if (mcnt <= 1) begin
          mpend <= 1'b0;
          if (!stub) begin
            mul_done   <= 1'b1;
            mul_result <= mprod;
          end
        end else begin
          mcnt <= mcnt - 1;
        end
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Stimulus: per-requester operand lists, consumed in order on accept.
  logic [W-1:0] op_a [N][32];
  logic [W-1:0] op_b [N][32];
  int           op_cnt [N];
  int           op_idx [N];
  int           rr_pct = 100;
  int           lat_fix = 0;

  // Reference model state.
  int          mptr = 0;
  bit          inflight = 1'b0;
  bit          start_due = 1'b0;
  int          exp_owner = 0;
  logic [W-1:0] exp_a, exp_b;
  logic [63:0] exp_res;
  logic        exp_err;
  int          exp_k = 0;
  int          acc_n = 0;
  int          ncyc = 0;
  int          glog[$];
  logic [63:0] res_of [N];
  logic [63:0] last_res = '0;
  logic        last_err = 1'b0;
  logic [N-1:0] last_vec = '0;

  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (op_idx[i] < op_cnt[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic clear_ops();
    for (int i = 0; i < N; i++) begin
      op_cnt[i] = 0;
      op_idx[i] = 0;
    end
  endtask

  task automatic add_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    if (op_cnt[r] < 32) begin
      op_a[r][op_cnt[r]] = a;
      op_b[r][op_cnt[r]] = b;
      op_cnt[r]++;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (op_idx[i] < op_cnt[i]);
      req_a[i*W +: W] = req_valid[i] ? op_a[i][op_idx[i]] : '0;
      req_b[i*W +: W] = req_valid[i] ? op_b[i][op_idx[i]] : '0;
      resp_ready[i] = ($urandom_range(0, 99) < rr_pct);
    end
  endtask

  // One clock: check at the falling edge, advance the model for the coming
  // rising edge, then present new inputs just after it.
  task automatic cycle();
    logic [N-1:0] oh;
    logic [N-1:0] exp_rv;
    bit was_busy;
    bit resp_now;
    int w;
    @(negedge clk);
    ncyc++;
    was_busy = inflight;
    chk("busy", 128'(busy), 128'(inflight));
    chk("mul_start", 128'(mul_start), 128'(start_due));
    if (start_due) begin
      chk("mul_a", 128'(mul_a), 128'(exp_a));
      chk("mul_b", 128'(mul_b), 128'(exp_b));
    end
    start_due = 1'b0;
    resp_now = inflight && (ncyc - acc_n - 1 >= exp_k);
    exp_rv = '0;
    if (resp_now) exp_rv[exp_owner] = 1'b1;
    chk("resp_valid", 128'(resp_valid), 128'(exp_rv));
    if (resp_now) begin
      chk("resp_result", 128'(resp_result), 128'(exp_res));
      chk("resp_err", 128'(resp_err), 128'(exp_err));
      if (resp_ready[exp_owner]) begin
        inflight = 1'b0;
        last_res = resp_result;
        last_err = resp_err;
        last_vec = resp_valid;
        res_of[exp_owner] = resp_result;
      end
    end
    oh = '0;
    if (!was_busy && (|req_valid)) begin
      w = winner(req_valid, mptr);
      oh[w] = 1'b1;
      chk("req_ready", 128'(req_ready), 128'(oh));
      inflight  = 1'b1;
      exp_owner = w;
      exp_a     = op_a[w][op_idx[w]];
      exp_b     = op_b[w][op_idx[w]];
      exp_err   = stub;
      exp_res   = stub ? 64'd0 : 64'(longint'($signed(exp_a)) * longint'($signed(exp_b)));
      mul_lat   = (lat_fix != 0) ? lat_fix : $urandom_range(2, 6);
      exp_k     = stub ? TO + 3 : mul_lat + 2;
      acc_n     = ncyc;
      start_due = 1'b1;
      mptr      = (w + 1) % N;
      op_idx[w]++;
      glog.push_back(w);
    end else begin
      chk("req_ready", 128'(req_ready), 128'(oh));
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    drive();
    while ((pending() || inflight) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain", 128'({pending(), inflight}), 128'(0));
  endtask

  task automatic check_reset_outputs();
    chk("rst_ctl", 128'({req_ready, resp_valid, resp_err, mul_start, busy}), 128'(0));
    chk("rst_data", {resp_result, mul_a, mul_b}, 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_exp [5];
    int post_exp [2];
    clear_ops();
    for (int i = 0; i < N; i++) res_of[i] = '0;

    // Reset state with reset held.
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs();
    end
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Round-robin: everyone requesting, requester 0 twice, pointer from reset.
    clear_ops();
    glog.delete();
    add_op(0, 32'h0000_0007, 32'h0000_0009);
    add_op(0, 32'h0000_0010, 32'h0000_0003);
    add_op(1, 32'hFFFF_FFFE, 32'h0000_0003);
    add_op(2, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    add_op(3, 32'hFFFF_FFFF, 32'h0000_0001);
    run(300);
    rr_exp = '{0, 1, 2, 3, 0};
    chk("rr_count", 128'(glog.size()), 128'(5));
    for (int i = 0; i < 5; i++) chk("rr_order", 128'(glog[i]), 128'(rr_exp[i]));
    chk("rr_r3_result", 128'(res_of[3]), 128'(64'hFFFF_FFFF_FFFF_FFFF));

    // Single request.
    clear_ops();
    add_op(0, 32'h0000_0010, 32'h0000_0010);
    run(100);
    chk("single_result", 128'(last_res), 128'(64'h0000_0000_0000_0100));
    chk("single_vec", 128'(last_vec), 128'(4'b0001));
    chk("single_err", 128'(last_err), 128'(0));

    // Signed operands.
    clear_ops();
    add_op(2, 32'h8000_0000, 32'h0000_0002);
    run(100);
    chk("signed_result", 128'(last_res), 128'(64'hFFFF_FFFF_0000_0000));
    chk("signed_vec", 128'(last_vec), 128'(4'b0100));

    // Response backpressure with another requester waiting.
    clear_ops();
    add_op(1, 32'h0000_0005, 32'h0000_0007);
    add_op(2, 32'hFFFF_FFF0, 32'h0000_0010);
    rr_pct = 0;
    drive();
    repeat (20) cycle();
    rr_pct = 100;
    run(200);
    chk("bp_result", 128'(res_of[1]), 128'(64'd35));

    // Timeout with a multiplier that never finishes.
    stub = 1'b1;
    clear_ops();
    add_op(0, 32'h0000_0003, 32'h0000_0004);
    run(400);
    stub = 1'b0;
    chk("timeout_err", 128'(last_err), 128'(1));
    chk("timeout_result", 128'(last_res), 128'(0));

    // Reset in the middle of WAIT; the late done must be ignored.
    clear_ops();
    lat_fix = 20;
    add_op(2, 32'h0000_1234, 32'h0000_0010);
    drive();
    repeat (6) cycle();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    inflight  = 1'b0;
    start_due = 1'b0;
    mptr      = 0;
    lat_fix   = 0;
    drive();
    repeat (25) cycle();
    glog.delete();
    add_op(1, 32'h0000_0003, 32'hFFFF_FFFD);
    add_op(3, 32'h0000_0002, 32'h0000_0002);
    run(200);
    post_exp = '{1, 3};
    chk("post_rst_count", 128'(glog.size()), 128'(2));
    for (int i = 0; i < 2; i++) chk("post_rst_order", 128'(glog[i]), 128'(post_exp[i]));
    chk("post_rst_result", 128'(res_of[1]), 128'(64'hFFFF_FFFF_FFFF_FFF7));

    // Randomised traffic with random backpressure and latency.
    clear_ops();
    rr_pct = 60;
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 8; j++) add_op($urandom_range(0, N - 1), pick(), pick());
      drive();
      repeat ($urandom_range(5, 40)) cycle();
    end
    run(3000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one sequential `signed_multiplier` among `N_REQ` requesters.

- Accepts operand pairs over per-requester valid/ready handshakes.
- Issues a one-cycle start pulse to the multiplier and waits for its `done`.
- Returns the 64-bit signed product to the requester that was granted.
- Sits between the requesting datapath blocks and the single multiplier instance; it owns the multiplier's `start`/`a`/`b` inputs.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `WIDTH`, 32: operand width; product is `2*WIDTH`.
- `TIMEOUT`, 255: maximum cycles to wait for `mul_done` before flagging an error.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  one-hot grant/accept; high only in IDLE, only for the winner.
- `req_a`, `req_b`  in  N_REQ*WIDTH  packed signed operands; requester i uses slice [i*WIDTH +: WIDTH].
- `resp_valid`  out  N_REQ  one-hot response valid to the owning requester.
- `resp_ready`  in  N_REQ  per-requester response accept.
- `resp_result`  out  2*WIDTH  signed product; shared bus, qualified by `resp_valid`.
- `resp_err`  out  1  timeout flag, qualified by `resp_valid`.
- `mul_start`  out  1  start pulse to the multiplier.
- `mul_a`, `mul_b`  out  WIDTH  operands to the multiplier.
- `mul_result`  in  2*WIDTH  multiplier product.
- `mul_done`  in  1  multiplier completion.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE → ISSUE: on any `req_valid`.
  - ISSUE → GUARD: unconditional.
  - GUARD → WAIT: unconditional.
  - WAIT → RESP: on `mul_done`, or when the timeout counter equals `TIMEOUT`.
  - RESP → IDLE: on `resp_ready[owner]`.
- Arbitration:
  - Round-robin pointer `ptr`, reset value 0.
  - Winner is the first asserted `req_valid` scanning `ptr`, `ptr+1`, … modulo `N_REQ`.
  - On accept, `ptr` becomes `owner+1` modulo `N_REQ`.
- Accept (IDLE, handshake): latch `owner`, `req_a` slice and `req_b` slice into internal registers. Requests arriving outside IDLE are not accepted; they stay pending.
- ISSUE: `mul_start`=1 for exactly one cycle. `mul_a`/`mul_b` are driven from the latches and held stable until RESP exits.
- GUARD: `mul_done` is ignored for this one cycle, so a `done` still asserted from the previous operation is never sampled. The multiplier clears `done` within one cycle of `start`.
- WAIT:
  - Timeout counter (8 bits minimum, sized from `TIMEOUT`) increments each cycle from 0.
  - On `mul_done`: capture `mul_result` into `resp_result`; `resp_err`=0.
  - On timeout: `resp_result`=0, `resp_err`=1.
- RESP:
  - `resp_valid[owner]`=1, other bits 0; `resp_result`/`resp_err` held stable until `resp_ready[owner]`.
  - `resp_ready` on non-owner bits is ignored.
- Arithmetic: none in this block; the product passes through bit-exact.
- `mul_done` is ignored in IDLE, ISSUE, GUARD and RESP.

## Timing
- Reset values:
  - All outputs 0 (`req_ready`, `resp_valid`, `resp_result`, `resp_err`, `mul_start`, `mul_a`, `mul_b`, `busy`).
  - State IDLE, `ptr`=0, timeout counter 0.
- Accept at edge T. Then:
  - `mul_start` high in cycle T+1.
  - GUARD in T+2.
  - `mul_done` is first sampled in T+3.
- `mul_done` sampled high at edge C → `resp_valid` high from C+1.
- Overhead beyond the multiplier latency is 3 cycles.
- Minimum accept-to-accept spacing is multiplier latency + 4 cycles (response taken in the same cycle it appears).
- Same requester re-requests immediately: it loses to any other pending requester (round-robin).
- Reset asserted mid-operation: return to IDLE immediately. A `mul_done` arriving after reset release is ignored in IDLE; no response is generated for the aborted request.

## Structure
- Shared package `mult_pkg`:
  - State enum: IDLE/ISSUE/GUARD/WAIT/RESP.
  - Default `WIDTH`.
  - `TIMEOUT` default.
- Sub-module `rr_arbiter`:
  - Parameter `N_REQ`.
  - Inputs: `req` vector, `ptr`.
  - Outputs: one-hot `grant`, `grant_idx`.
  - Purely combinational.
- FSM, latches, timeout counter and `ptr` register live in `mult_arbiter`.
- Bench instantiates `mult_arbiter` with the real `signed_multiplier`. A second configuration uses a stub multiplier that never asserts `done`.

## Test plan
- Single request: requester 0, a=0x00000010, b=0x00000010 → one `mul_start` pulse; `resp_valid`=4'b0001, `resp_result`=0x0000000000000100, `resp_err`=0.
- Signed operands: requester 2, a=0x80000000, b=0x00000002 → `resp_valid`=4'b0100, `resp_result`=0xFFFFFFFF00000000.
- Round-robin fairness: all four `req_valid` held high with distinct operands → grants 0,1,2,3,0, each `resp_result` matching its own operands (e.g. 0xFFFFFFFF×0x00000001 → 0xFFFFFFFFFFFFFFFF on requester 3).
- Response backpressure: `resp_ready` low for 10 cycles → `resp_valid`/`resp_result` stable, no new `req_ready`, `mul_start` stays 0.
- Timeout: stub multiplier never asserts `done` → `resp_valid` exactly `TIMEOUT`+3 cycles after accept, `resp_err`=1, `resp_result`=0.
- Reset mid-WAIT: `rst` low for 2 cycles during WAIT → all outputs 0, `ptr`=0; the late `mul_done` produces no response; the next request from requester 1 completes normally.
